// File: rtl/err_compute.sv
// Sequences eight A2D conversions, forms a weighted right-minus-left error and a raw-sum line detect.
// Latency 8*(2+cnv wait)+2 cycles from start; waits indefinitely on cnv_cmplt, start ignored while busy.
module err_compute #(
  parameter logic [14:0] LINE_THRES = 15'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        busy,
  output logic [10:0] err_sat,
  output logic        err_vld,
  output logic        line_present
);

  typedef enum logic [1:0] {IDLE, CNV, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic               strt_cnv_q, strt_cnv_d;
  logic               err_vld_q, err_vld_d;
  logic [10:0]        err_sat_q, err_sat_d;
  logic               line_present_q, line_present_d;
  logic signed [16:0] acc_q, acc_d;
  logic [14:0]        total_q, total_d;

  logic signed [16:0] wres;
  logic signed [16:0] acc_shr;
  logic [10:0]        acc_sat;

  // Channel pairs share a weight: ch0/1 x1, ch2/3 x2, ch4/5 x4, ch6/7 x8.
  assign wres    = signed'({5'b0, res} << chnnl_q[2:1]);
  assign acc_shr = acc_q >>> 3;

  always_comb begin
    acc_sat = acc_shr[10:0];
    if (acc_shr > 17'sd1023) begin
      acc_sat = 11'h3FF;
    end else if (acc_shr < -17'sd1024) begin
      acc_sat = 11'h400;
    end
  end

  always_comb begin
    state_d        = state_q;
    chnnl_d        = chnnl_q;
    strt_cnv_d     = 1'b0;
    err_vld_d      = 1'b0;
    err_sat_d      = err_sat_q;
    line_present_d = line_present_q;
    acc_d          = acc_q;
    total_d        = total_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = '0;
          total_d    = '0;
          chnnl_d    = 3'd0;
          strt_cnv_d = 1'b1;
          state_d    = CNV;
        end
      end
      CNV: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) begin
          acc_d   = chnnl_q[0] ? (acc_q + wres) : (acc_q - wres);
          total_d = total_q + {3'b0, res};
          if (chnnl_q == 3'd7) begin
            state_d = DONE;
          end else begin
            chnnl_d    = chnnl_q + 3'd1;
            strt_cnv_d = 1'b1;
            state_d    = CNV;
          end
        end
      end
      DONE: begin
        err_sat_d      = acc_sat;
        line_present_d = (total_q > LINE_THRES);
        err_vld_d      = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      chnnl_q        <= 3'd0;
      strt_cnv_q     <= 1'b0;
      err_vld_q      <= 1'b0;
      err_sat_q      <= 11'd0;
      line_present_q <= 1'b0;
      acc_q          <= '0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      chnnl_q        <= chnnl_d;
      strt_cnv_q     <= strt_cnv_d;
      err_vld_q      <= err_vld_d;
      err_sat_q      <= err_sat_d;
      line_present_q <= line_present_d;
      acc_q          <= acc_d;
      total_q        <= total_d;
    end
  end

  assign strt_cnv     = strt_cnv_q;
  assign chnnl        = chnnl_q;
  assign busy         = (state_q != IDLE);
  assign err_sat      = err_sat_q;
  assign err_vld      = err_vld_q;
  assign line_present = line_present_q;

endmodule

// File: doc/err_compute.md
ERR_COMPUTE -- requirements
Module: err_compute

Interface
REQ-001 SHALL have parameter LINE_THRES, default 15'd2048: line-detect threshold on the unsigned sum of all eight readings.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one full error computation; sampled only in IDLE.
REQ-005 SHALL have port strt_cnv  output  1  one-cycle pulse requesting an A2D conversion on chnnl.
REQ-006 SHALL have port chnnl  output  3  A2D channel being converted, 0..7.
REQ-007 SHALL have port cnv_cmplt  input  1  A2D conversion done; res valid while high.
REQ-008 SHALL have port res  input  12  unsigned A2D result.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port err_sat  output  11  signed saturated error, consumed by the integrator and P/D stages.
REQ-011 SHALL have port err_vld  output  1  one-cycle pulse; err_sat and line_present are new this cycle.
REQ-012 SHALL have port line_present  output  1  registered line-detect flag; the integrator clears on its rise.

Function
REQ-013 SHALL implement FSM states IDLE, CNV, WAIT, DONE.
REQ-014 IDLE: when start=1, SHALL clear the accumulator and total, set chnnl=0, and go to CNV; otherwise SHALL stay in IDLE.
REQ-015 CNV: SHALL assert strt_cnv for exactly this one cycle, then go to WAIT; cnv_cmplt seen in CNV SHALL be ignored.
REQ-016 WAIT: SHALL hold chnnl stable and sample res only on a cycle with cnv_cmplt=1; SHALL wait indefinitely with no timeout.
REQ-017 On sample, if chnnl<7, SHALL increment chnnl and go to CNV; if chnnl=7, SHALL go to DONE.
REQ-018 Channel map, with weight w: ch0 L1 w1, ch1 R1 w1, ch2 L2 w2, ch3 R2 w2, ch4 L3 w4, ch5 R3 w4, ch6 L4 w8, ch7 R4 w8.
REQ-019 Signed 17-bit accumulator: acc += res*w for right channels (odd); acc -= res*w for left channels (even).
REQ-020 Range: |acc| ≤ 61425, so the accumulator SHALL never overflow.
REQ-021 Unsigned 15-bit total SHALL sum all raw res values (max 32760).
REQ-022 DONE: SHALL register err_sat = sat11(acc >>> 3), using an arithmetic floor shift, and register line_present = (total > LINE_THRES).
REQ-023 DONE: SHALL set registered err_vld=1 and then go to IDLE.
REQ-024 Result: err_vld SHALL be high for exactly one cycle, coincident with the new err_sat and line_present.
REQ-025 sat11 SHALL clamp to +1023 (11'h3FF) if the value is >1023, and to -1024 (11'h400) if the value is <-1024; otherwise it SHALL pass the value through.
REQ-026 err_sat and line_present SHALL hold their values between err_vld pulses.
REQ-027 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-028 start high in the same cycle err_vld is high: the FSM is already in IDLE, so the request SHALL be accepted.
REQ-029 Latency: SHALL equal 8×(2 + cnv_cmplt wait cycles) + 2 cycles from start sampled to err_vld; with cnv_cmplt arriving on the first WAIT cycle, this SHALL be 18 cycles.
REQ-030 strt_cnv SHALL be a registered, glitch-free output.
REQ-031 chnnl SHALL change only on CNV entry.

Reset
REQ-032 rst_n low SHALL act asynchronously: state=IDLE, chnnl=0, strt_cnv=0, busy=0, err_vld=0, err_sat=0, line_present=0, accumulator=0, total=0.
REQ-033 Reset mid-conversion SHALL abort the conversion with no err_vld.
REQ-034 After reset, a cnv_cmplt from the aborted conversion SHALL be ignored in IDLE.

Verification
REQ-035 All res=0 -> err_vld single pulse, err_sat=0, line_present=0, 8 strt_cnv pulses with chnnl sequence 0..7.
REQ-036 ch7=4095, others 0 -> acc=32760, err_sat=+1023 (saturated), line_present=1.
REQ-037 ch6=4095, others 0 -> err_sat=-1024 (11'h400, saturated), line_present=1; ch1=80 only -> err_sat=+10, line_present=0; ch0=9 only -> err_sat=-2 (floor).
REQ-038 Balanced run with ch0..7 all 300 -> acc=0, err_sat=0, total=2400 -> line_present=1; then all 256 -> total=2048 -> line_present=0 (strictly greater required).
REQ-039 rst_n asserted in WAIT on ch4 -> all outputs 0 immediately, no err_vld; a stray cnv_cmplt in IDLE causes no action; the next start completes normally.
REQ-040 start pulsed during busy, and cnv_cmplt delayed 5 cycles per channel -> only one err_vld, at 58 cycles after the accepted start.
